// File: rtl/accel_host_driver.sv
// accel_host_driver: host-side buffers and serial sequencer feeding the
// accelerator top (ifmap/filter load, compute wait, result drain).
module accel_host_driver #(
    parameter int IFMAP_BYTES    = 25,
    parameter int FILTER_BYTES   = 9,
    parameter int OUT_BYTES      = 9,
    parameter int COMPUTE_CYCLES = 12,
    parameter int OUT_SKIP       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       done_serial,
    output logic [7:0] acc_ifmap,
    output logic [7:0] acc_filter,
    input  logic [7:0] acc_out
);

    localparam int DRAIN_CYCLES = OUT_SKIP + OUT_BYTES;
    localparam int F_OFS        = IFMAP_BYTES - FILTER_BYTES;
    localparam int MAX_A        = (IFMAP_BYTES > COMPUTE_CYCLES) ?
                                  IFMAP_BYTES : COMPUTE_CYCLES;
    localparam int MAX_P        = (MAX_A > DRAIN_CYCLES) ?
                                  MAX_A : DRAIN_CYCLES;
    localparam int CW           = $clog2(MAX_P + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_COMP  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic [7:0] ifmap_buf [IFMAP_BYTES];
    logic [7:0] filt_buf  [FILTER_BYTES];
    logic [7:0] res_buf   [OUT_BYTES];

    logic       ifm_we;
    logic       flt_we;
    logic       load_last;
    logic       comp_last;
    logic       drain_last;
    logic [7:0] ifm_first;
    logic [7:0] flt_first;
    logic [7:0] ifm_nxt;
    logic [7:0] flt_nxt;
    logic [7:0] rd_val;

    assign cnt_nxt    = cnt + CW'(1);
    assign load_last  = (cnt == CW'(IFMAP_BYTES - 1));
    assign comp_last  = (cnt == CW'(COMPUTE_CYCLES - 1));
    assign drain_last = (cnt == CW'(DRAIN_CYCLES - 1));

    // host writes land only while idle; out-of-range addresses match no entry
    assign ifm_we = wr_en && !wr_sel && (state == S_IDLE);
    assign flt_we = wr_en &&  wr_sel && (state == S_IDLE);

    // buffer read muxes, including same-cycle write bypass for byte 0
    always_comb begin
        ifm_nxt   = 8'h00;
        flt_nxt   = 8'h00;
        rd_val    = 8'h00;
        ifm_first = ifmap_buf[0];
        flt_first = 8'h00;
        if (ifm_we && (wr_addr == 5'd0)) begin
            ifm_first = wr_data;
        end
        if (F_OFS == 0) begin
            flt_first = (flt_we && (wr_addr == 5'd0)) ?
                        wr_data : filt_buf[0];
        end
        for (int i = 0; i < IFMAP_BYTES; i++) begin
            if (cnt_nxt == CW'(i)) begin
                ifm_nxt = ifmap_buf[i];
            end
        end
        for (int j = 0; j < FILTER_BYTES; j++) begin
            if (cnt_nxt == CW'(j + F_OFS)) begin
                flt_nxt = filt_buf[j];
            end
        end
        for (int k = 0; k < OUT_BYTES; k++) begin
            if (rd_addr == 4'(k)) begin
                rd_val = res_buf[k];
            end
        end
    end

    // ifmap buffer: host writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IFMAP_BYTES; i++) begin
                ifmap_buf[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < IFMAP_BYTES; i++) begin
                if (ifm_we && (wr_addr == 5'(i))) begin
                    ifmap_buf[i] <= wr_data;
                end
            end
        end
    end

    // filter buffer: host writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < FILTER_BYTES; j++) begin
                filt_buf[j] <= 8'h00;
            end
        end else begin
            for (int j = 0; j < FILTER_BYTES; j++) begin
                if (flt_we && (wr_addr == 5'(j))) begin
                    filt_buf[j] <= wr_data;
                end
            end
        end
    end

    // result buffer: capture drain samples after the skipped ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < OUT_BYTES; k++) begin
                res_buf[k] <= 8'h00;
            end
        end else if (state == S_DRAIN) begin
            for (int k = 0; k < OUT_BYTES; k++) begin
                if (cnt == CW'(k + OUT_SKIP)) begin
                    res_buf[k] <= acc_out;
                end
            end
        end
    end

    // registered result read port, active in every state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= rd_val;
        end
    end

    // job sequencer: load -> compute -> drain -> done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            done_serial <= 1'b0;
            acc_ifmap   <= 8'h00;
            acc_filter  <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        done_serial <= 1'b1;
                        acc_ifmap   <= ifm_first;
                        acc_filter  <= flt_first;
                    end
                end
                S_LOAD: begin
                    if (load_last) begin
                        state       <= S_COMP;
                        cnt         <= '0;
                        done_serial <= 1'b0;
                        acc_ifmap   <= 8'h00;
                        acc_filter  <= 8'h00;
                    end else begin
                        cnt        <= cnt_nxt;
                        acc_ifmap  <= ifm_nxt;
                        acc_filter <= flt_nxt;
                    end
                end
                S_COMP: begin
                    if (comp_last) begin
                        state       <= S_DRAIN;
                        cnt         <= '0;
                        done_serial <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                S_DRAIN: begin
                    if (drain_last) begin
                        state       <= S_DONE;
                        cnt         <= '0;
                        done_serial <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    cnt         <= '0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    done_serial <= 1'b0;
                    acc_ifmap   <= 8'h00;
                    acc_filter  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_host_driver.sv
// tb_accel_host_driver: timeline model of a job plus directed
// scenarios for load order, drain capture, aborts and bounds.
module tb_accel_host_driver;

    localparam int IFM     = 25;
    localparam int FLT     = 9;
    localparam int OUTB    = 9;
    localparam int CC      = 12;
    localparam int SKIP    = 1;
    localparam int F_OFS   = IFM - FLT;
    localparam int DR_BEG  = IFM + CC + 1;
    localparam int DR_END  = IFM + CC + SKIP + OUTB;
    localparam int JOB_LEN = DR_END + 1;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       wr_sel;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       done_serial;
    logic [7:0] acc_ifmap;
    logic [7:0] acc_filter;
    logic [7:0] acc_out;

    accel_host_driver dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .done_serial (done_serial),
        .acc_ifmap   (acc_ifmap),
        .acc_filter  (acc_filter),
        .acc_out     (acc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      nm, act, exp, $time);
    endtask

    // model: t = cycles since start accept (0 = idle)
    logic [7:0] m_ifm [IFM];
    logic [7:0] m_flt [FLT];
    logic [7:0] m_res [OUTB];
    logic [7:0] m_rd;
    int         t = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            t    <= 0;
            m_rd <= 8'h00;
            for (int i = 0; i < IFM; i++) m_ifm[i] <= 8'h00;
            for (int i = 0; i < FLT; i++) m_flt[i] <= 8'h00;
            for (int i = 0; i < OUTB; i++) m_res[i] <= 8'h00;
        end else begin
            m_rd <= (rd_addr < OUTB) ? m_res[rd_addr] : 8'h00;
            if (t == 0) begin
                if (wr_en && !wr_sel && wr_addr < IFM)
                    m_ifm[wr_addr] <= wr_data;
                if (wr_en && wr_sel && wr_addr < FLT)
                    m_flt[wr_addr] <= wr_data;
                if (start) t <= 1;
            end else begin
                if (t >= DR_BEG + SKIP && t <= DR_END)
                    m_res[t - DR_BEG - SKIP] <= acc_out;
                t <= (t == JOB_LEN) ? 0 : t + 1;
            end
        end
    end

    function automatic logic e_ds(int tt);
        return (tt >= 1 && tt <= IFM) || (tt >= DR_BEG && tt <= DR_END);
    endfunction

    function automatic logic [7:0] e_if(int tt);
        if (tt >= 1 && tt <= IFM) return m_ifm[tt-1];
        return 8'h00;
    endfunction

    function automatic logic [7:0] e_fl(int tt);
        if (tt >= F_OFS + 1 && tt <= IFM) return m_flt[tt-1-F_OFS];
        return 8'h00;
    endfunction

    // accelerator stand-in: drain cycle k presents 0x10+k
    initial begin
        acc_out = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            acc_out = (t >= DR_BEG && t <= DR_END) ?
                      8'(8'h10 + t - DR_BEG) : 8'h5A;
        end
    end

    logic [7:0] seq_if [IFM];
    logic [7:0] seq_fl [IFM];

    // per-cycle comparison against the model
    always @(negedge clk) begin
        check("cyc_busy", busy, (t >= 1));
        check("cyc_done", done, (t == JOB_LEN));
        check("cyc_done_serial", done_serial, e_ds(t));
        check("cyc_acc_ifmap", acc_ifmap, e_if(t));
        check("cyc_acc_filter", acc_filter, e_fl(t));
        check("cyc_rd_data", rd_data, m_rd);
        if (t >= 1 && t <= IFM) begin
            seq_if[t-1] <= acc_ifmap;
            seq_fl[t-1] <= acc_filter;
        end
    end

    bit ds_log [0:255];

    task automatic wr(input logic sel, input logic [4:0] a,
                      input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e,
                      input string nm);
        rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        check(nm, rd_data, e);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input bit do_wr, input logic [7:0] wd,
                           input bit inject, output int n);
        bit got = 0;
        int i = 1;
        int h1 = 0;
        int lo = 0;
        int h2 = 0;
        start = 1'b1;
        if (do_wr) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = wd;
        end
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            ds_log[n] = done_serial;
            if (inject && n == 2) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0;
                wr_addr = 5'd3; wr_data = 8'hFF;
            end
            if (inject && n == 3) begin
                start = 1'b0; wr_en = 1'b0;
            end
            if (done) got = 1;
        end
        check("job_done_seen", got, 1'b1);
        // 25 load + 12 compute + 1 skip + 9 drain + 1 done
        check("job_len", n, 48);
        while (i <= n && ds_log[i]) begin h1++; i++; end
        while (i <= n && !ds_log[i]) begin lo++; i++; end
        while (i <= n && ds_log[i]) begin h2++; i++; end
        check("ds_load_high", h1, 25);
        check("ds_compute_low", lo, 12);
        check("ds_drain_high", h2, 10);
        @(posedge clk); #1;
    endtask

    int n;
    int dn;

    initial begin
        wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0;
        start = 0; rd_addr = 0;
        rst = 1'b1;
        #1 rst = 1'b0;

        // reset held with random inputs
        repeat (4) begin
            @(posedge clk); #1;
            wr_en   = 1'($urandom);
            wr_sel  = 1'($urandom);
            wr_addr = 5'($urandom);
            wr_data = 8'($urandom);
            start   = 1'($urandom);
            rd_addr = 4'($urandom);
        end
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_done_serial", done_serial, 1'b0);
        check("rst_acc_ifmap", acc_ifmap, 8'h00);
        check("rst_acc_filter", acc_filter, 8'h00);
        check("rst_rd_data", rd_data, 8'h00);
        wr_en = 0; start = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        rd(4'd5, 8'h00, "rd_after_reset");

        // load ordering; ifmap[0] rewritten in the start cycle
        for (int i = 1; i < IFM; i++) wr(1'b0, 5'(i), 8'(i + 1));
        wr(1'b0, 5'd0, 8'h77);
        for (int j = 0; j < FLT; j++) wr(1'b1, 5'(j), 8'(8'hA0 + j));
        run_job(1'b1, 8'h01, 1'b0, n);
        for (int i = 0; i < IFM; i++)
            check("load_ifmap_seq", seq_if[i], 8'(i + 1));
        for (int i = 0; i < IFM; i++)
            check("load_filter_seq", seq_fl[i],
                  (i < 16) ? 8'h00 : 8'(8'hA0 + i - 16));
        for (int k = 0; k < OUTB; k++)
            rd(4'(k), 8'(8'h11 + k), "result_byte");
        for (int k = 9; k < 16; k++)
            rd(4'(k), 8'h00, "rd_out_of_range");

        // start and write during LOAD are ignored
        run_job(1'b0, 8'h00, 1'b1, n);
        check("inject_ifmap3", seq_if[3], 8'h04);
        run_job(1'b0, 8'h00, 1'b0, n);
        check("after_inject_ifmap3", seq_if[3], 8'h04);

        // out-of-range writes
        wr(1'b0, 5'd25, 8'hEE);
        wr(1'b1, 5'd9, 8'hEE);
        wr(1'b1, 5'd31, 8'hEE);
        run_job(1'b0, 8'h00, 1'b0, n);
        check("bounds_ifmap24", seq_if[24], 8'h19);
        check("bounds_filter8", seq_fl[24], 8'hA8);
        check("bounds_ifmap0", seq_if[0], 8'h01);

        // abort in the middle of COMPUTE
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_done_serial", done_serial, 1'b0);
        check("abort_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        dn = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        @(posedge clk); #1;
        for (int k = 0; k < OUTB; k++)
            rd(4'(k), 8'h00, "abort_result_cleared");
        run_job(1'b0, 8'h00, 1'b0, n);
        check("post_abort_ifmap0", seq_if[0], 8'h00);
        rd(4'd0, 8'h11, "post_abort_result0");
        rd(4'd8, 8'h19, "post_abort_result8");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
